// File: rtl/tlb_flush_ctrl_pkg.sv
// Shared types for the SFENCE.VMA flush controller: FSM states and the latched flush request.
package tlb_flush_ctrl_pkg;

    localparam int ASID_MAX_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_WALK,
        ST_DONE
    } flush_state_e;

    // ASIDs are zero-extended to ASID_MAX_W so one struct serves every ASID_W <= 16.
    typedef struct packed {
        logic                  flush_all;
        logic                  addr_valid;
        logic [31:0]           vaddr;
        logic                  asid_valid;
        logic [ASID_MAX_W-1:0] asid;
    } flush_req_t;

    function automatic logic is_full_flush(flush_req_t r);
        return r.flush_all || !(r.addr_valid || r.asid_valid);
    endfunction

endpackage

// File: rtl/tlb_flush_match.sv
// Combinational per-entry SFENCE match for one TLB read port; zero latency, no flow control.
module tlb_flush_match
    import tlb_flush_ctrl_pkg::*;
#(
    parameter int ASID_W = 9
) (
    input  logic                  full_i,
    input  logic                  addr_vld_i,
    input  logic                  asid_vld_i,
    input  logic [19:0]           vpn_i,
    input  logic [ASID_MAX_W-1:0] asid_i,
    input  logic                  e_valid_i,
    input  logic                  e_global_i,
    input  logic                  e_mega_i,
    input  logic [19:0]           e_vpn_i,
    input  logic [ASID_W-1:0]     e_asid_i,
    output logic                  inval_o
);

    logic vpn_eq;
    logic asid_eq;

    // A megapage entry covers 4 MiB, so only the upper ten VPN bits take part.
    assign vpn_eq  = e_mega_i ? (vpn_i[19:10] == e_vpn_i[19:10]) : (vpn_i == e_vpn_i);
    assign asid_eq = (asid_i == ASID_MAX_W'(e_asid_i));

    always_comb begin
        inval_o = 1'b0;
        if (e_valid_i) begin
            if (full_i)
                inval_o = 1'b1;
            else if (addr_vld_i && asid_vld_i)
                inval_o = vpn_eq && asid_eq && !e_global_i;
            else if (addr_vld_i)
                inval_o = vpn_eq;
            else
                inval_o = asid_eq && !e_global_i;
        end
    end

endmodule

// File: rtl/tlb_flush_ctrl.sv
// SFENCE.VMA controller: full flush done 2 cycles after accept, selective walk done TLB_ENTRIES+1 after.
// req_ready only in IDLE; HARVOS_SFENCE_QUEUE_EN adds a one-deep pending buffer that launches right after DONE.
module tlb_flush_ctrl
    import tlb_flush_ctrl_pkg::*;
#(
    parameter int TLB_ENTRIES = 16,
    parameter int ASID_W      = 9
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_flush_all,
    input  logic                           req_addr_valid,
    input  logic [31:0]                    req_vaddr,
    input  logic                           req_asid_valid,
    input  logic [ASID_W-1:0]              req_asid,
    output logic [$clog2(TLB_ENTRIES)-1:0] walk_idx,
    input  logic                           itlb_e_valid,
    input  logic                           itlb_e_global,
    input  logic                           itlb_e_mega,
    input  logic [19:0]                    itlb_e_vpn,
    input  logic [ASID_W-1:0]              itlb_e_asid,
    input  logic                           dtlb_e_valid,
    input  logic                           dtlb_e_global,
    input  logic                           dtlb_e_mega,
    input  logic [19:0]                    dtlb_e_vpn,
    input  logic [ASID_W-1:0]              dtlb_e_asid,
    output logic                           itlb_inval,
    output logic                           dtlb_inval,
    output logic                           tlb_flush_all,
    output logic                           busy,
    output logic                           done
);

    localparam int             IDX_W    = $clog2(TLB_ENTRIES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLB_ENTRIES - 1);

    flush_state_e     state_q;
    logic [IDX_W-1:0] walk_idx_q;
    flush_req_t       cur_q;
    logic             flush_all_q;
    logic             done_q;

    flush_req_t in_req;
    flush_req_t launch_req;
    logic       accept;
    logic       launch_vld;
    logic       itlb_hit;
    logic       dtlb_hit;
    logic       unused_page_off;

    always_comb begin
        in_req            = '0;
        in_req.flush_all  = req_flush_all;
        in_req.addr_valid = req_addr_valid;
        in_req.vaddr      = req_vaddr;
        in_req.asid_valid = req_asid_valid;
        in_req.asid       = ASID_MAX_W'(req_asid);
    end

    assign accept = req_valid && req_ready;

`ifdef HARVOS_SFENCE_QUEUE_EN
    flush_req_t pend_q;
    logic       pend_vld_q;
    logic       in_flight;

    assign in_flight  = (state_q == ST_FLUSH) || (state_q == ST_WALK);
    assign req_ready  = (state_q == ST_IDLE) || !pend_vld_q;
    assign launch_vld = !in_flight && (pend_vld_q || accept);
    assign launch_req = pend_vld_q ? pend_q : in_req;
    assign busy       = (state_q != ST_IDLE) || pend_vld_q;

    // A request arriving during DONE with an empty buffer launches directly and never parks here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
        end else if (accept && in_flight) begin
            pend_q     <= in_req;
            pend_vld_q <= 1'b1;
        end else if (launch_vld) begin
            pend_vld_q <= 1'b0;
        end
    end
`else
    assign req_ready  = (state_q == ST_IDLE);
    assign launch_vld = accept;
    assign launch_req = in_req;
    assign busy       = (state_q != ST_IDLE);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            walk_idx_q  <= '0;
            cur_q       <= '0;
            flush_all_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            flush_all_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (launch_vld) begin
                        cur_q      <= launch_req;
                        walk_idx_q <= '0;
                        if (is_full_flush(launch_req)) begin
                            state_q     <= ST_FLUSH;
                            flush_all_q <= 1'b1;
                        end else begin
                            state_q <= ST_WALK;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
                end
                ST_WALK: begin
                    if (walk_idx_q == LAST_IDX) begin
                        state_q    <= ST_DONE;
                        done_q     <= 1'b1;
                        walk_idx_q <= '0;
                    end else begin
                        walk_idx_q <= walk_idx_q + IDX_W'(1);
                    end
                end
            endcase
        end
    end

    tlb_flush_match #(.ASID_W(ASID_W)) u_itlb_match (
        .full_i     (is_full_flush(cur_q)),
        .addr_vld_i (cur_q.addr_valid),
        .asid_vld_i (cur_q.asid_valid),
        .vpn_i      (cur_q.vaddr[31:12]),
        .asid_i     (cur_q.asid),
        .e_valid_i  (itlb_e_valid),
        .e_global_i (itlb_e_global),
        .e_mega_i   (itlb_e_mega),
        .e_vpn_i    (itlb_e_vpn),
        .e_asid_i   (itlb_e_asid),
        .inval_o    (itlb_hit)
    );

    tlb_flush_match #(.ASID_W(ASID_W)) u_dtlb_match (
        .full_i     (is_full_flush(cur_q)),
        .addr_vld_i (cur_q.addr_valid),
        .asid_vld_i (cur_q.asid_valid),
        .vpn_i      (cur_q.vaddr[31:12]),
        .asid_i     (cur_q.asid),
        .e_valid_i  (dtlb_e_valid),
        .e_global_i (dtlb_e_global),
        .e_mega_i   (dtlb_e_mega),
        .e_vpn_i    (dtlb_e_vpn),
        .e_asid_i   (dtlb_e_asid),
        .inval_o    (dtlb_hit)
    );

    // Page offset is latched with the request but never takes part in matching.
    assign unused_page_off = ^cur_q.vaddr[11:0];

    assign walk_idx      = walk_idx_q;
    assign itlb_inval    = (state_q == ST_WALK) && itlb_hit;
    assign dtlb_inval    = (state_q == ST_WALK) && dtlb_hit;
    assign tlb_flush_all = flush_all_q;
    assign done          = done_q;

endmodule

// File: tb/tb_tlb_flush_ctrl.sv
// Directed bench for tlb_flush_ctrl: per-cycle compare against a request-timeline model plus literal checks.
module tb_tlb_flush_ctrl;

    localparam int N  = 16;
    localparam int AW = 9;
`ifdef HARVOS_SFENCE_QUEUE_EN
    localparam bit QUEUE = 1'b1;
`else
    localparam bit QUEUE = 1'b0;
`endif

    typedef struct {
        bit          valid;
        bit          glb;
        bit          mega;
        bit [19:0]   vpn;
        bit [AW-1:0] asid;
    } tb_ent_t;

    typedef struct {
        bit          flush_all;
        bit          addr_valid;
        bit          asid_valid;
        bit [31:0]   vaddr;
        bit [AW-1:0] asid;
    } tb_req_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_flush_all = 1'b0;
    logic          req_addr_valid = 1'b0;
    logic [31:0]   req_vaddr = '0;
    logic          req_asid_valid = 1'b0;
    logic [AW-1:0] req_asid = '0;
    logic [3:0]    walk_idx;
    logic          itlb_e_valid, itlb_e_global, itlb_e_mega;
    logic [19:0]   itlb_e_vpn;
    logic [AW-1:0] itlb_e_asid;
    logic          dtlb_e_valid, dtlb_e_global, dtlb_e_mega;
    logic [19:0]   dtlb_e_vpn;
    logic [AW-1:0] dtlb_e_asid;
    logic          itlb_inval, dtlb_inval, tlb_flush_all, busy, done;

    tb_ent_t itlb[N];
    tb_ent_t dtlb[N];

    assign itlb_e_valid  = itlb[walk_idx].valid;
    assign itlb_e_global = itlb[walk_idx].glb;
    assign itlb_e_mega   = itlb[walk_idx].mega;
    assign itlb_e_vpn    = itlb[walk_idx].vpn;
    assign itlb_e_asid   = itlb[walk_idx].asid;
    assign dtlb_e_valid  = dtlb[walk_idx].valid;
    assign dtlb_e_global = dtlb[walk_idx].glb;
    assign dtlb_e_mega   = dtlb[walk_idx].mega;
    assign dtlb_e_vpn    = dtlb[walk_idx].vpn;
    assign dtlb_e_asid   = dtlb[walk_idx].asid;

    tlb_flush_ctrl #(.TLB_ENTRIES(N), .ASID_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_flush_all(req_flush_all), .req_addr_valid(req_addr_valid), .req_vaddr(req_vaddr),
        .req_asid_valid(req_asid_valid), .req_asid(req_asid),
        .walk_idx(walk_idx),
        .itlb_e_valid(itlb_e_valid), .itlb_e_global(itlb_e_global), .itlb_e_mega(itlb_e_mega),
        .itlb_e_vpn(itlb_e_vpn), .itlb_e_asid(itlb_e_asid),
        .dtlb_e_valid(dtlb_e_valid), .dtlb_e_global(dtlb_e_global), .dtlb_e_mega(dtlb_e_mega),
        .dtlb_e_vpn(dtlb_e_vpn), .dtlb_e_asid(dtlb_e_asid),
        .itlb_inval(itlb_inval), .dtlb_inval(dtlb_inval), .tlb_flush_all(tlb_flush_all),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;
    bit chk_en = 1'b0;
    int ihits[$];
    int dhits[$];
    int done_cyc[$];
    int flush_cyc[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc + 1);
        end
    endtask

    // ---------------- reference model: accepted requests run in order, one timeline each ----------------
    tb_req_t mq[$];
    int      m_n = 0;

    function automatic bit is_flush(tb_req_t r);
        return r.flush_all || (!r.addr_valid && !r.asid_valid);
    endfunction

    function automatic int req_len(tb_req_t r);
        return is_flush(r) ? 2 : N + 1;
    endfunction

    function automatic bit ready_exp();
        return (mq.size() == 0) || (QUEUE && mq.size() == 1);
    endfunction

    function automatic bit hit(tb_ent_t e, tb_req_t r);
        bit vpn_eq, asid_eq;
        if (!e.valid) return 1'b0;
        vpn_eq  = e.mega ? (r.vaddr[31:22] == e.vpn[19:10]) : (r.vaddr[31:12] == e.vpn);
        asid_eq = (r.asid == e.asid);
        if (r.addr_valid && r.asid_valid) return vpn_eq && asid_eq && !e.glb;
        if (r.addr_valid) return vpn_eq;
        return asid_eq && !e.glb;
    endfunction

    initial forever @(posedge clk) cyc++;

    initial begin
        bit      acc;
        tb_req_t r;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                m_n = 0;
            end else begin
                acc = req_valid && ready_exp();
                if (mq.size() > 0) begin
                    if (m_n == req_len(mq[0])) begin
                        void'(mq.pop_front());
                        m_n = (mq.size() > 0) ? 1 : 0;
                    end else begin
                        m_n++;
                    end
                end
                if (acc) begin
                    r.flush_all  = req_flush_all;
                    r.addr_valid = req_addr_valid;
                    r.asid_valid = req_asid_valid;
                    r.vaddr      = req_vaddr;
                    r.asid       = req_asid;
                    mq.push_back(r);
                    if (mq.size() == 1) m_n = 1;
                end
            end
        end
    end

    // ---------------- per-cycle compare, mid low phase of the clock ----------------
    initial begin
        bit      act, wk;
        int      idx;
        tb_req_t h;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                act = (mq.size() > 0);
                h   = act ? mq[0] : '{default: 0};
                wk  = act && !is_flush(h) && (m_n <= N);
                idx = wk ? m_n - 1 : 0;
                chk("req_ready", 32'(req_ready), 32'(ready_exp()));
                chk("busy", 32'(busy), 32'(act));
                chk("done", 32'(done), 32'(act && m_n == req_len(h)));
                chk("tlb_flush_all", 32'(tlb_flush_all), 32'(act && is_flush(h) && m_n == 1));
                chk("walk_idx", 32'(walk_idx), 32'(idx));
                chk("itlb_inval", 32'(itlb_inval), 32'(wk && hit(itlb[idx], h)));
                chk("dtlb_inval", 32'(dtlb_inval), 32'(wk && hit(dtlb[idx], h)));
                if (done === 1'b1) done_cyc.push_back(cyc + 1);
                if (tlb_flush_all === 1'b1) flush_cyc.push_back(cyc + 1);
                if (itlb_inval === 1'b1) ihits.push_back(int'(walk_idx));
                if (dtlb_inval === 1'b1) dhits.push_back(int'(walk_idx));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic clear_logs();
        ihits.delete(); dhits.delete(); done_cyc.delete(); flush_cyc.delete();
    endtask

    // Called in the low phase; t returns the number of the accepting clock edge.
    task automatic send(bit fa, bit av, bit [31:0] va, bit sv, bit [AW-1:0] as, output int t);
        int k;
        req_valid = 1'b1; req_flush_all = fa; req_addr_valid = av;
        req_vaddr = va; req_asid_valid = sv; req_asid = as;
        for (k = 0; k < 200 && req_ready !== 1'b1; k++) @(negedge clk);
        if (k == 200) chk("accept_timeout", 32'(req_ready), 32'd1);
        t = cyc + 1;
        @(negedge clk);
        req_valid = 1'b0;
        req_flush_all = 1'($urandom_range(0, 1)); req_addr_valid = 1'($urandom_range(0, 1));
        req_vaddr = $urandom; req_asid_valid = 1'($urandom_range(0, 1)); req_asid = AW'($urandom);
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 300 && busy !== 1'b0; k++) @(negedge clk);
        if (k == 300) chk("idle_timeout", 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    function automatic int lat(int q[$], int pos, int base);
        return (q.size() > pos) ? q[pos] - base : -1;
    endfunction

    initial begin
        int t, t1, t2, k;
        for (int i = 0; i < N; i++) begin
            itlb[i] = '{default: 0};
            dtlb[i] = '{default: 0};
        end
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;
        chk("reset_ready", 32'(req_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_walk_idx", 32'(walk_idx), 32'd0);

        // Full flush
        clear_logs();
        send(1'b1, 1'b0, 32'h0, 1'b0, '0, t);
        wait_idle();
        chk("flush_strobe_cycle", 32'(lat(flush_cyc, 0, t)), 32'd1);
        chk("flush_done_cycle", 32'(lat(done_cyc, 0, t)), 32'd2);
        chk("flush_no_inval", 32'(ihits.size() + dhits.size()), 32'd0);

        // Address-only, global entry included
        itlb[5] = '{1, 1, 0, 20'h00403, 0};
        dtlb[5] = '{1, 0, 0, 20'h00404, 0};
        clear_logs();
        send(1'b0, 1'b1, 32'h0040_3000, 1'b0, '0, t);
        wait_idle();
        chk("addr_itlb_count", 32'(ihits.size()), 32'd1);
        chk("addr_itlb_idx", 32'(ihits.size() > 0 ? ihits[0] : 99), 32'd5);
        chk("addr_dtlb_count", 32'(dhits.size()), 32'd0);
        chk("addr_done_cycle", 32'(lat(done_cyc, 0, t)), 32'd17);

        // ASID-only: global and invalid entries are skipped
        dtlb[2] = '{1, 0, 0, 20'h12345, 3};
        dtlb[7] = '{1, 1, 0, 20'h23456, 3};
        dtlb[9] = '{0, 0, 0, 20'h34567, 3};
        clear_logs();
        send(1'b0, 1'b0, 32'h0, 1'b1, 9'd3, t);
        wait_idle();
        chk("asid_dtlb_count", 32'(dhits.size()), 32'd1);
        chk("asid_dtlb_idx", 32'(dhits.size() > 0 ? dhits[0] : 99), 32'd2);
        chk("asid_itlb_count", 32'(ihits.size()), 32'd0);

        // Megapage match on the upper VPN only
        itlb[11] = '{1, 0, 1, 20'h00400, 7};
        itlb[12] = '{1, 0, 0, 20'h00400, 7};
        clear_logs();
        send(1'b0, 1'b1, 32'h0043_F000, 1'b0, '0, t);
        wait_idle();
        chk("mega_itlb_count", 32'(ihits.size()), 32'd1);
        chk("mega_itlb_idx", 32'(ihits.size() > 0 ? ihits[0] : 99), 32'd11);
        chk("mega_dtlb_count", 32'(dhits.size()), 32'd0);

        // Address + ASID
        dtlb[3] = '{1, 0, 0, 20'h00403, 5};
        dtlb[4] = '{1, 0, 0, 20'h00403, 6};
        clear_logs();
        send(1'b0, 1'b1, 32'h0040_3000, 1'b1, 9'd5, t);
        wait_idle();
        chk("both_dtlb_count", 32'(dhits.size()), 32'd1);
        chk("both_dtlb_idx", 32'(dhits.size() > 0 ? dhits[0] : 99), 32'd3);
        chk("both_itlb_count", 32'(ihits.size()), 32'd0);

        // No qualifier at all takes the flush path
        clear_logs();
        send(1'b0, 1'b0, 32'hDEAD_B000, 1'b0, '0, t);
        wait_idle();
        chk("noqual_flush_count", 32'(flush_cyc.size()), 32'd1);
        chk("noqual_done_cycle", 32'(lat(done_cyc, 0, t)), 32'd2);

        // Second request offered at T+3, while a walk is running
        for (int c = 0; c < 2; c++) begin
            clear_logs();
            send(1'b0, 1'b1, 32'h0040_3000, 1'b0, '0, t1);
            repeat (2) @(negedge clk);
            chk("ready_at_T3", 32'(req_ready), QUEUE ? 32'd1 : 32'd0);
            send(c == 0, c == 1, 32'h0040_3000, 1'b0, '0, t2);
            wait_idle();
            chk("second_accept_edge", 32'(t2 - t1), QUEUE ? 32'd3 : 32'd18);
            chk("first_done_cycle", 32'(lat(done_cyc, 0, t1)), 32'd17);
            chk("done_gap", 32'(done_cyc.size() == 2 ? done_cyc[1] - done_cyc[0] : -1),
                32'((c == 0 ? 2 : 17) + (QUEUE ? 0 : 1)));
        end

        // Reset in the middle of a walk
        dtlb[12] = '{1, 0, 0, 20'h00403, 0};
        send(1'b0, 1'b1, 32'h0040_3000, 1'b0, '0, t);
        for (k = 0; k < 40 && walk_idx !== 4'd8; k++) @(negedge clk);
        chk("reached_idx8", 32'(walk_idx), 32'd8);
        #2 rst_n = 1'b0;
        clear_logs();
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", 32'(req_ready), 32'd1);
        repeat (25) @(negedge clk);
        chk("abort_no_inval", 32'(ihits.size() + dhits.size()), 32'd0);
        chk("abort_no_done", 32'(done_cyc.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", vecs, errs);
        $fatal(1);
    end

endmodule

// File: doc/tlb_flush_ctrl.md
TLB_FLUSH_CTRL -- requirements
Module: tlb_flush_ctrl

Interface
REQ-001 SHALL have parameter TLB_ENTRIES, default 16, entries per TLB (power of two, 2..64).
REQ-002 SHALL have parameter ASID_W, default 9, ASID width.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  in  1  SFENCE request offered by the pulse from the SFENCE.VMA decoder.
REQ-006 req_ready  out  1  request accepted when req_valid and req_ready are both high.
REQ-007 req_flush_all  in  1  invalidate every entry.
REQ-008 req_addr_valid  in  1  restrict invalidation to req_vaddr.
REQ-009 req_vaddr  in  32  virtual address.
REQ-010 req_asid_valid  in  1  restrict invalidation to req_asid.
REQ-011 req_asid  in  ASID_W  address-space ID.
REQ-012 walk_idx  out  $clog2(TLB_ENTRIES)  shared index, driven to both TLB read ports.
REQ-013 itlb_e_valid, itlb_e_global, itlb_e_mega  in  1 each  ITLB entry flags at walk_idx, combinational.
REQ-014 itlb_e_vpn  in  20  ITLB entry VPN.  itlb_e_asid  in  ASID_W  ITLB entry ASID.
REQ-015 dtlb_e_* : same five inputs for the DTLB.
REQ-016 itlb_inval, dtlb_inval  out  1 each  invalidate the entry at walk_idx at the next clock edge.
REQ-017 tlb_flush_all  out  1  one-cycle strobe that clears both TLBs entirely.
REQ-018 busy  out  1  pipeline stall; high from acceptance through the done cycle.
REQ-019 done  out  1  one-cycle completion pulse.

Function
REQ-020 FSM states: IDLE, FLUSH, WALK, DONE.
REQ-021 IDLE->FLUSH on acceptance with req_flush_all=1, or with req_addr_valid=0 and req_asid_valid=0; tlb_flush_all SHALL be high only in FLUSH.
REQ-022 IDLE->WALK on any other accepted request; walk_idx SHALL start at 0 and advance by 1 per cycle in WALK.
REQ-023 WALK->DONE on the cycle walk_idx==TLB_ENTRIES-1; walk_idx SHALL then wrap to 0. FLUSH->DONE after one cycle.
REQ-024 Latency: acceptance at edge T; FLUSH request gives done in cycle T+2; walk request gives done in cycle T+TLB_ENTRIES+1.
REQ-025 Match rule per entry (valid required): vpn_eq = e_mega ? vaddr[31:22]==e_vpn[19:10] : vaddr[31:12]==e_vpn.
REQ-026 Address-only: invalidate if vpn_eq, global entries included.
REQ-027 ASID-only: invalidate if asid equal and !e_global.
REQ-028 Address+ASID: invalidate if vpn_eq and asid equal and !e_global.
REQ-029 itlb_inval/dtlb_inval SHALL be asserted only in WALK, evaluated independently per TLB.
REQ-030 Request fields SHALL be latched at acceptance; input changes during a walk SHALL have no effect.
REQ-031 DONE->IDLE, or DONE->FLUSH/WALK directly when a pending request exists (REQ-036).
REQ-032 busy = (state != IDLE) or pending request held.

Reset
REQ-033 On rst_n low, state SHALL become IDLE, walk_idx 0, pending cleared, and done, busy, inval and flush strobes 0; req_ready SHALL be 1 in the first cycle after release.
REQ-034 Reset asserted mid-walk SHALL abort the walk without any further inval strobe; no done pulse for the aborted request.

Configuration
REQ-035 Macro HARVOS_SFENCE_QUEUE_EN.
REQ-036 Defined: one-entry pending buffer; req_ready = IDLE or buffer empty; a request accepted while busy SHALL start in the cycle after its predecessor's DONE, giving back-to-back done pulses separated by the new latency.
REQ-037 Undefined: req_ready = (state==IDLE) only; no buffer.

Structure
REQ-038 The FSM state enum and a flush-request struct (flush_all, addr_valid, vaddr, asid_valid, asid) SHALL go in harvos_pkg_flat.svh.
REQ-039 A sub-module tlb_flush_match SHALL hold the combinational per-entry match (REQ-025..028) and be instantiated once per TLB.

Verification
REQ-040 flush_all request, TLB_ENTRIES=16 -> tlb_flush_all high one cycle at T+1, done at T+2, no inval strobes.
REQ-041 Address-only vaddr=0x0040_3000; entry 5 {vpn=0x00403, global=1} -> itlb_inval only at walk_idx=5; done at T+17.
REQ-042 ASID-only asid=3; entries {asid=3, global=0} at 2 and {asid=3, global=1} at 7 -> inval at 2 only.
REQ-043 Megapage entry vpn=0x00400, mega=1, vaddr=0x0043_F000 -> inval at that index.
REQ-044 Reset pulsed at walk_idx=8 -> no further inval, no done, req_ready=1 after release.
REQ-045 With HARVOS_SFENCE_QUEUE_EN, second request at T+3 -> accepted; second done 17 cycles after first (walk) or 2 cycles after (flush). Without the macro, req_ready=0 until IDLE.
